// File: rtl/round_timer_score.sv
// Round clock and miss scoring for the gate game.
// Drives BCD elapsed time, miss count and the VGA blank window.
module round_timer_score #(
    parameter int TICK_DIV     = 50000000,
    parameter int BLANK_CYCLES = 25000000,
    parameter int PENALTY_S    = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        timer_en,
    input  logic        blank_req,
    input  logic [8:0]  completed_gate,
    output logic [11:0] sec_bcd,
    output logic [3:0]  miss_count,
    output logic        vga_blank,
    output logic        running,
    output logic        finished
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PW-1:0] TMAX   = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BMAX   = BW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] PEN_TH = BW'(BLANK_CYCLES - PENALTY_S);

    typedef enum logic [1:0] {IDLE, RUN, BLANK, DONE} state_t;

    state_t        state, state_d;
    logic [2:0]    en_sr, bq_sr;
    logic [PW-1:0] presc;
    logic [BW-1:0] blank_cnt;
    logic          en_rise, en_fall, bq_rise;
    logic          active, start, tick, penalty, won;
    logic          vga_d, running_d, finished_d;
    logic [11:0]   sec_t, sec_next;

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // bit0/bit1 form the synchronizer, bit2 is the edge reference
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_sr <= '0;
            bq_sr <= '0;
        end else begin
            en_sr <= {en_sr[1:0], timer_en};
            bq_sr <= {bq_sr[1:0], blank_req};
        end
    end

    assign en_rise = en_sr[1] & ~en_sr[2];
    assign en_fall = ~en_sr[1] & en_sr[2];
    assign bq_rise = bq_sr[1] & ~bq_sr[2];
    assign won     = (completed_gate == 9'h1FF);
    assign active  = (state == RUN) || (state == BLANK);
    assign start   = ((state == IDLE) || (state == DONE)) && en_rise;
    assign tick    = active && (presc == TMAX);
    assign penalty = (state == BLANK) && (blank_cnt >= PEN_TH);
    assign sec_t    = tick ? bcd_inc(sec_bcd) : sec_bcd;
    assign sec_next = penalty ? bcd_inc(sec_t) : sec_t;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, DONE: begin
                if (en_rise) state_d = RUN;
            end
            RUN: begin
                if (en_fall)      state_d = won ? DONE : IDLE;
                else if (bq_rise) state_d = BLANK;
            end
            BLANK: begin
                if (en_fall)                state_d = won ? DONE : IDLE;
                else if (blank_cnt == '0)   state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vga_d      = (state_d == BLANK);
        running_d  = (state_d == RUN) || (state_d == BLANK);
        finished_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vga_blank <= 1'b0;
            running   <= 1'b0;
            finished  <= 1'b0;
        end else begin
            vga_blank <= vga_d;
            running   <= running_d;
            finished  <= finished_d;
        end
    end

    // the detected timer_en fall freezes every counter for that cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc      <= '0;
            blank_cnt  <= '0;
            sec_bcd    <= '0;
            miss_count <= '0;
        end else if (start) begin
            presc      <= '0;
            blank_cnt  <= '0;
            sec_bcd    <= '0;
            miss_count <= '0;
        end else if (active && !en_fall) begin
            presc   <= tick ? '0 : presc + 1'b1;
            sec_bcd <= sec_next;
            if ((state == RUN) && bq_rise) begin
                miss_count <= (miss_count == 4'hF) ? miss_count : miss_count + 4'd1;
                blank_cnt  <= BMAX;
            end else if ((state == BLANK) && (blank_cnt != '0)) begin
                blank_cnt <= blank_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_round_timer_score.sv
// Randomized scoreboard bench for round_timer_score.
// An integer-seconds reference model predicts every cycle's outputs.
module tb_round_timer_score;

    localparam int TICK  = 4;
    localparam int BLANK = 8;
    localparam int PEN   = 3;

    typedef struct packed {
        logic [11:0] sec;
        logic [3:0]  miss;
        logic        vga;
        logic        run;
        logic        fin;
    } obs_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        timer_en = 1'b0;
    logic        blank_req = 1'b0;
    logic [8:0]  completed_gate = '0;
    logic [11:0] sec_bcd;
    logic [3:0]  miss_count;
    logic        vga_blank, running, finished;

    int n_cmp = 0;
    int n_err = 0;
    int n_cyc = 0;
    obs_t q[$];

    // reference model: plain integers, events delayed by two sampled edges
    int m_sec, m_miss, m_cyc, m_left;
    bit m_active, m_done;
    bit te_h[3];
    bit br_h[3];

    round_timer_score #(
        .TICK_DIV(TICK),
        .BLANK_CYCLES(BLANK),
        .PENALTY_S(PEN)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .timer_en(timer_en),
        .blank_req(blank_req),
        .completed_gate(completed_gate),
        .sec_bcd(sec_bcd),
        .miss_count(miss_count),
        .vga_blank(vga_blank),
        .running(running),
        .finished(finished)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        m_sec = 0; m_miss = 0; m_cyc = 0; m_left = 0;
        m_active = 0; m_done = 0;
        for (int i = 0; i < 3; i++) begin
            te_h[i] = 0;
            br_h[i] = 0;
        end
    endfunction

    function automatic void model_step(bit te, bit br, logic [8:0] cg);
        bit rise_en, fall_en, rise_br;
        int inc;
        rise_en = te_h[1] && !te_h[2];
        fall_en = !te_h[1] && te_h[2];
        rise_br = br_h[1] && !br_h[2];
        if (m_active) begin
            if (fall_en) begin
                m_active = 0;
                m_done   = (cg == 9'h1FF);
                m_left   = 0;
            end else begin
                inc = 0;
                m_cyc++;
                if (m_cyc == TICK) begin
                    m_cyc = 0;
                    inc++;
                end
                if (m_left > 0) begin
                    if (BLANK - m_left < PEN) inc++;
                    m_left--;
                end else if (rise_br) begin
                    m_miss = (m_miss < 15) ? m_miss + 1 : 15;
                    m_left = BLANK;
                end
                m_sec = (m_sec + inc > 999) ? 999 : m_sec + inc;
            end
        end else if (rise_en) begin
            m_active = 1; m_done = 0;
            m_sec = 0; m_miss = 0; m_cyc = 0; m_left = 0;
        end
        te_h[2] = te_h[1]; te_h[1] = te_h[0]; te_h[0] = te;
        br_h[2] = br_h[1]; br_h[1] = br_h[0]; br_h[0] = br;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.sec  = {4'(m_sec / 100), 4'((m_sec / 10) % 10), 4'(m_sec % 10)};
        o.miss = 4'(m_miss);
        o.vga  = (m_left > 0);
        o.run  = m_active;
        o.fin  = m_done;
        return o;
    endfunction

    task automatic cycle(input bit te, input bit br, input logic [8:0] cg);
        #1;
        timer_en = te;
        blank_req = br;
        completed_gate = cg;
        @(posedge clk);
        model_step(te, br, cg);
        q.push_back(model_obs());
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int dut_all();
        return int'({sec_bcd, miss_count, vga_blank, running, finished});
    endfunction

    // monitor: every sampled cycle is one DUT output to score
    always @(negedge clk) begin
        obs_t e, a;
        n_cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {sec_bcd, miss_count, vga_blank, running, finished};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL scoreboard cyc=%0d got sec=%h miss=%0d vga=%b run=%b fin=%b expected sec=%h miss=%0d vga=%b run=%b fin=%b",
                         n_cyc, a.sec, a.miss, a.vga, a.run, a.fin,
                         e.sec, e.miss, e.vga, e.run, e.fin);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit te, br;
        logic [8:0] cg;
        model_clear();
        #2 resetn = 1'b0;
        #1 chk("reset_outputs", dut_all(), 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        repeat (5) cycle(0, 0, 9'h0);
        repeat (40) cycle(1, 0, 9'h0);
        chk("basic_vga_low", int'(vga_blank), 0);

        cycle(1, 1, 9'h0); cycle(1, 1, 9'h0);
        repeat (3) cycle(1, 0, 9'h0);
        cycle(1, 1, 9'h0); cycle(1, 1, 9'h0);
        repeat (15) cycle(1, 0, 9'h0);
        chk("miss_once", int'(miss_count), 1);

        repeat (20) cycle(0, 0, 9'h1FF);
        chk("win_finished", int'(finished), 1);
        chk("win_running", int'(running), 0);
        repeat (10) cycle(1, 0, 9'h0);
        chk("restart_finished", int'(finished), 0);

        cycle(0, 1, 9'h0);
        repeat (10) cycle(0, 0, 9'h0);

        repeat (20) cycle(1, 0, 9'h0);
        repeat (10) cycle(0, 0, 9'h0FF);
        chk("abort_finished", int'(finished), 0);

        repeat (4100) cycle(1, 0, 9'h0);
        @(negedge clk);
        chk("sec_saturate", int'(sec_bcd), 12'h999);

        for (int i = 0; i < 17; i++) begin
            cycle(1, 1, 9'h0); cycle(1, 1, 9'h0);
            repeat (14) cycle(1, 0, 9'h0);
        end
        @(negedge clk);
        chk("miss_saturate", int'(miss_count), 15);

        te = 1; br = 0; cg = 9'h0;
        repeat (600) begin
            if ($urandom_range(0, 39) == 0) te = ~te;
            if ($urandom_range(0, 5) == 0) br = ~br;
            if ($urandom_range(0, 1) == 0) cg = 9'h1FF;
            else cg = 9'($urandom);
            cycle(te, br, cg);
        end

        repeat (20) cycle(1, 0, 9'h0);
        cycle(1, 1, 9'h0); cycle(1, 1, 9'h0);
        repeat (3) cycle(1, 0, 9'h0);
        @(negedge clk);
        chk("pre_reset_blank", int'(vga_blank), 1);
        #1 resetn = 1'b0;
        #1 chk("async_reset", dut_all(), 0);
        q.delete();
        model_clear();
        @(posedge clk);
        #1 resetn = 1'b1;

        repeat (60) cycle(1, 1'($urandom_range(0, 1)), 9'h0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/round_timer_score.md
Name: round_timer_score

Overview:
- Downstream consumer of the gate-selection controller's game status: `timer_en`, `vga_blankout` and `completed_gate`.
- Runs the round clock while a round is active and counts misses.
- Stretches each miss into a fixed-length VGA blank window and adds a time penalty per miss.
- Latches the final time when all nine gates are completed.
- Its BCD and status outputs feed the HEX display decoders and the VGA blank control.

Parameters:
- TICK_DIV, 50000000: clk cycles per elapsed second (CLOCK_50 -> 1 s).
- BLANK_CYCLES, 25000000: length of the vga_blank window per miss, in clk cycles (min 2).
- PENALTY_S, 5: seconds added to elapsed time per miss (1..9; must be <= BLANK_CYCLES).

Ports:
- clk  input  1  system clock (CLOCK_50)
- resetn  input  1  asynchronous active-low reset
- timer_en  input  1  round-active level from gate controller
- blank_req  input  1  miss indication level (gate controller vga_blankout)
- completed_gate  input  9  completed-gate mask; all ones = round won
- sec_bcd  output  12  elapsed seconds, 3 BCD digits [11:8]=hundreds, [3:0]=units
- miss_count  output  4  misses this round, saturating
- vga_blank  output  1  high during the blank window after a miss
- running  output  1  high in RUN or BLANK state
- finished  output  1  high in DONE state; sec_bcd frozen

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE.
  - sec_bcd=12'h000, miss_count=0, vga_blank=0, running=0, finished=0.
  - Prescaler, blank counter, synchronizers and edge registers all cleared.
- Input conditioning:
  - timer_en and blank_req each pass through a 2-flop synchronizer plus one edge register.
  - An input transition acts on the state at the 3rd rising clk edge after it.
  - completed_gate is sampled unsynchronized, only on the cycle the timer_en falling edge is detected; it is stable by then.
- States: IDLE, RUN, BLANK, DONE.
- IDLE:
  - Outputs hold their last values.
  - On a timer_en rise: clear sec_bcd, miss_count and the prescaler; go to RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; on reaching TICK_DIV-1 it wraps to 0 and sec_bcd increments by 1.
  - On a blank_req rise: miss_count += 1 (saturate at 15), load the blank counter, go to BLANK.
- BLANK:
  - vga_blank=1 for exactly BLANK_CYCLES cycles; the prescaler keeps counting.
  - In each of the first PENALTY_S cycles of BLANK, sec_bcd increments by 1.
  - If a prescaler tick coincides with a penalty cycle, sec_bcd increments by 2 that cycle.
  - blank_req rises during BLANK are ignored: no count, no restart.
  - When the window expires: vga_blank=0, return to RUN.
- timer_en fall, from RUN or BLANK:
  - If completed_gate == 9'h1FF: go to DONE; finished=1; sec_bcd frozen; vga_blank forced 0.
  - Otherwise (aborted round): go to IDLE, vga_blank=0, counters hold.
- DONE:
  - sec_bcd and miss_count hold.
  - On a timer_en rise: same as from IDLE (clear, go to RUN, finished=0).
- BCD arithmetic:
  - Each digit wraps 9->0 with carry to the next digit.
  - sec_bcd saturates at 999; further increments (tick or penalty) leave it at 999.
- Simultaneous events: a timer_en fall and a blank_req rise detected in the same cycle -> the timer_en fall wins and the miss is not counted.
- Outputs:
  - running is high iff state is RUN or BLANK; finished is high iff state is DONE.
  - All outputs are registered.

Test Plan (TICK_DIV=4, BLANK_CYCLES=8, PENALTY_S=3):
- Basic timing: resetn low then high; raise timer_en; hold 40 cycles -> running=1 from the 3rd edge; sec_bcd=12'h010 at 40 cycles after start (+/-1 cycle); vga_blank=0 throughout.
- Miss penalty: in RUN at sec_bcd=12'h002, pulse blank_req high 2 cycles:
  - miss_count=1 and vga_blank=1 for exactly 8 cycles.
  - sec_bcd reaches 12'h005 within the first 3 BLANK cycles, plus any ticks.
  - A second blank_req pulse inside the window -> miss_count stays 1.
- Win: completed_gate=9'h1FF, drop timer_en -> finished=1, running=0; sec_bcd frozen for 20 further cycles. Raising timer_en again -> sec_bcd=0, miss_count=0, finished=0.
- Abort and saturation:
  - Drop timer_en with completed_gate=9'h0FF -> IDLE, finished=0, values held.
  - Preload near 999 (run ~4000 cycles) -> sec_bcd sticks at 12'h999.
  - 17 separated misses -> miss_count=15.
- Wrap and reset mid-operation:
  - Digit carry 12'h099 -> 12'h100 on one tick.
  - Assert resetn low mid-BLANK -> vga_blank and all outputs 0 immediately (asynchronous, no clk edge needed).
